// File: rtl/my_processor_pkg.sv
// Shared ISA encodings, FSM states and flag layout for the multi-cycle core.
package my_processor_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FUNC_W  = 4;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_C = 3;

    localparam logic [1:0] OP_ALU_R = 2'b00;
    localparam logic [1:0] OP_ALU_I = 2'b01;
    localparam logic [1:0] OP_MEM   = 2'b10;
    localparam logic [1:0] OP_CTL   = 2'b11;

    localparam logic [FUNC_W-1:0] F_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] F_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] F_AND = 4'd2;
    localparam logic [FUNC_W-1:0] F_OR  = 4'd3;
    localparam logic [FUNC_W-1:0] F_XOR = 4'd4;
    localparam logic [FUNC_W-1:0] F_NOT = 4'd5;
    localparam logic [FUNC_W-1:0] F_SLL = 4'd6;
    localparam logic [FUNC_W-1:0] F_SRL = 4'd7;
    localparam logic [FUNC_W-1:0] F_SRA = 4'd8;
    localparam logic [FUNC_W-1:0] F_CMP = 4'd9;

    localparam logic [FUNC_W-1:0] F_LD = 4'd0;
    localparam logic [FUNC_W-1:0] F_ST = 4'd1;

    localparam logic [FUNC_W-1:0] F_B    = 4'd0;
    localparam logic [FUNC_W-1:0] F_BR   = 4'd1;
    localparam logic [FUNC_W-1:0] F_BZ   = 4'd2;
    localparam logic [FUNC_W-1:0] F_BNZ  = 4'd3;
    localparam logic [FUNC_W-1:0] F_BCY  = 4'd4;
    localparam logic [FUNC_W-1:0] F_BNCY = 4'd5;
    localparam logic [FUNC_W-1:0] F_BS   = 4'd6;
    localparam logic [FUNC_W-1:0] F_BNS  = 4'd7;
    localparam logic [FUNC_W-1:0] F_BV   = 4'd8;
    localparam logic [FUNC_W-1:0] F_BNV  = 4'd9;
    localparam logic [FUNC_W-1:0] F_CALL = 4'd10;
    localparam logic [FUNC_W-1:0] F_RET  = 4'd11;
    localparam logic [FUNC_W-1:0] F_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [FUNC_W-1:0] func;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    // True for every op/func pair the core implements.
    function automatic logic is_legal(input logic [1:0] op, input logic [FUNC_W-1:0] func);
        case (op)
            OP_ALU_R, OP_ALU_I: return func <= F_CMP;
            OP_MEM:             return func <= F_ST;
            default:            return (func <= F_RET) || (func == F_HALT);
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU with carry/sign/overflow/zero flag generation.
module mc_alu
    import my_processor_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] operand0,
    input  logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] result_c,
    output logic              carry_c,
    output logic              sign_c,
    output logic              ovf_c,
    output logic              zero_c
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned MSB  = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [SH_W-1:0] shamt;

    always_comb begin
        sum      = {1'b0, operand0} + {1'b0, operand1};
        diff     = {1'b0, operand0} - {1'b0, operand1};
        shamt    = operand1[SH_W-1:0];
        result_c = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        case (func)
            F_ADD: begin
                result_c = sum[DATA_W-1:0];
                carry_c  = sum[DATA_W];
                ovf_c    = (operand0[MSB] == operand1[MSB]) && (sum[MSB] != operand0[MSB]);
            end
            // diff's top bit is the unsigned borrow
            F_SUB, F_CMP: begin
                result_c = diff[DATA_W-1:0];
                carry_c  = diff[DATA_W];
                ovf_c    = (operand0[MSB] != operand1[MSB]) && (diff[MSB] != operand0[MSB]);
            end
            F_AND:   result_c = operand0 & operand1;
            F_OR:    result_c = operand0 | operand1;
            F_XOR:   result_c = operand0 ^ operand1;
            F_NOT:   result_c = ~operand0;
            F_SLL:   result_c = operand0 << shamt;
            F_SRL:   result_c = operand0 >> shamt;
            F_SRA:   result_c = DATA_W'($signed(operand0) >>> shamt);
            default: result_c = '0;
        endcase
        sign_c = result_c[MSB];
        zero_c = (result_c == '0);
    end

endmodule

// File: rtl/my_processor_mc.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB FSM over one req/ack memory port.
module my_processor_mc
    import my_processor_pkg::*;
#(
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      ADDR_W     = 16,
    parameter int unsigned      REG_ADDR_W = 5,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam int unsigned          NREGS  = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] RA_IDX = '1;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    instr_t               ir_q, ir_d;
    logic [DATA_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    logic [DATA_W-1:0]    regs_q [NREGS];
    logic [DATA_W-1:0]    regs_d [NREGS];
    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic                 halted_q, halted_d, illegal_q, illegal_d;

    logic [REG_ADDR_W-1:0] rs_idx, rt_idx;
    logic [DATA_W-1:0]     imm_ext, alu_opnd1, alu_res;
    logic                  alu_c, alu_s, alu_v, alu_z, br_cond;
    logic [ADDR_W-1:0]     pc_inc, target_pc, data_addr, ctl_next_pc;

    assign rs_idx    = REG_ADDR_W'(ir_q.rs);
    assign rt_idx    = REG_ADDR_W'(ir_q.rt);
    assign imm_ext   = {{(DATA_W-IMM_W){ir_q.imm[IMM_W-1]}}, ir_q.imm};
    assign alu_opnd1 = (ir_q.op == OP_ALU_I) ? imm_ext : op_b_q;
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign target_pc = pc_inc + ADDR_W'(imm_ext);
    assign data_addr = ADDR_W'(op_a_q + imm_ext);

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .func     (ir_q.func),
        .operand0 (op_a_q),
        .operand1 (alu_opnd1),
        .result_c (alu_res),
        .carry_c  (alu_c),
        .sign_c   (alu_s),
        .ovf_c    (alu_v),
        .zero_c   (alu_z)
    );

    // Control-flow resolution against the stored flags.
    always_comb begin
        br_cond = 1'b0;
        case (ir_q.func)
            F_B, F_CALL: br_cond = 1'b1;
            F_BZ:        br_cond = flags_q[FLAG_Z];
            F_BNZ:       br_cond = !flags_q[FLAG_Z];
            F_BCY:       br_cond = flags_q[FLAG_C];
            F_BNCY:      br_cond = !flags_q[FLAG_C];
            F_BS:        br_cond = flags_q[FLAG_S];
            F_BNS:       br_cond = !flags_q[FLAG_S];
            F_BV:        br_cond = flags_q[FLAG_V];
            F_BNV:       br_cond = !flags_q[FLAG_V];
            default:     br_cond = 1'b0;
        endcase
        ctl_next_pc = br_cond ? target_pc : pc_inc;
        if (ir_q.func == F_BR)  ctl_next_pc = ADDR_W'(op_a_q);
        if (ir_q.func == F_RET) ctl_next_pc = ADDR_W'(regs_q[RA_IDX]);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        flags_d     = flags_q;
        regs_d      = regs_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        case (state_q)
            // Request is launched one cycle after reset, otherwise on entry.
            S_FETCH: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ack) begin
                    ir_d      = instr_t'(mem_rdata[INSTR_W-1:0]);
                    mem_req_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_d = regs_q[rs_idx];
                op_b_d = regs_q[rt_idx];
                if (!is_legal(ir_q.op, ir_q.func)) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else if (ir_q.op == OP_CTL && ir_q.func == F_HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_q.op)
                    OP_ALU_R, OP_ALU_I: begin
                        res_d           = alu_res;
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_S] = alu_s;
                        flags_d[FLAG_V] = alu_v;
                        flags_d[FLAG_Z] = alu_z;
                        state_d         = S_WB;
                    end
                    OP_MEM: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ir_q.func == F_ST);
                        mem_addr_d  = data_addr;
                        mem_wdata_d = (ir_q.func == F_ST) ? op_b_q : '0;
                        state_d     = S_MEM;
                    end
                    default: begin
                        if (ir_q.func == F_CALL) regs_d[RA_IDX] = DATA_W'(pc_inc);
                        pc_d       = ctl_next_pc;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = ctl_next_pc;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    if (ir_q.func == F_LD) begin
                        res_d     = mem_rdata;
                        mem_req_d = 1'b0;
                        state_d   = S_WB;
                    end else begin
                        pc_d       = pc_inc;
                        mem_addr_d = pc_inc;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                if (ir_q.op == OP_MEM)       regs_d[rt_idx] = res_q;
                else if (ir_q.func != F_CMP) regs_d[rs_idx] = res_q;
                pc_d       = pc_inc;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_inc;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                halted_d  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            regs_q      <= '{default: '0};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            regs_q      <= regs_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
